// File: rtl/pml_pkg.sv
// Shared definitions for the program-memory loader.
// Holds the loader FSM state type, the default frame sync byte and the
// program-memory geometry shared with the program memory and core decode.
// Optional build macro used by the loader: PML_TIMEOUT_EN.
package pml_pkg;

  // Program memory geometry: 11-bit PC, 14-bit instruction words.
  localparam int unsigned PML_ADDR_W = 11;
  localparam int unsigned PML_DATA_W = 14;

  localparam logic [7:0] PML_SYNC_BYTE = 8'hA5;

  typedef enum logic [2:0] {
    StIdle,
    StLenHi,
    StLenLo,
    StWHi,
    StWLo,
    StChk,
    StDone,
    StErr
  } pml_state_e;

  // True while a frame is being received (between SYNC and the end of CHK).
  function automatic logic pml_in_frame(pml_state_e s);
    return (s == StLenHi) || (s == StLenLo) || (s == StWHi) || (s == StWLo) || (s == StChk);
  endfunction

endpackage

// File: rtl/pml_word_asm.sv
// Byte-pair to instruction-word assembler for the program-memory loader.
// Latches the HI byte, and on the LO byte issues a one-cycle program-memory
// write of {hi[5:0], lo} at the supplied index.
// Ports:
//   clk, rst_n   clock, asynchronous active-low reset
//   clr          frame start: return write address to 0
//   hi_load      accept a valid HI byte
//   lo_load      accept a LO byte and launch the write
//   rx_byte      incoming byte
//   wr_idx       word index for the write being launched
//   hi_bad       HI byte reserved bits [7:6] are nonzero
//   pm_we        one-cycle write strobe
//   pm_addr      write address, held between writes
//   pm_wdata     write data
module pml_word_asm
  import pml_pkg::*;
#(
  parameter int unsigned ADDR_W = PML_ADDR_W,
  parameter int unsigned DATA_W = PML_DATA_W
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              clr,
  input  logic              hi_load,
  input  logic              lo_load,
  input  logic [7:0]        rx_byte,
  input  logic [ADDR_W-1:0] wr_idx,
  output logic              hi_bad,
  output logic              pm_we,
  output logic [ADDR_W-1:0] pm_addr,
  output logic [DATA_W-1:0] pm_wdata
);

  logic [5:0]        hi_q;
  logic              we_q;
  logic [ADDR_W-1:0] addr_q;
  logic [DATA_W-1:0] wdata_q;

  assign hi_bad = |rx_byte[7:6];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hi_q    <= '0;
      we_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
    end else begin
      we_q <= lo_load;
      if (hi_load) begin
        hi_q <= rx_byte[5:0];
      end
      if (lo_load) begin
        addr_q  <= wr_idx;
        wdata_q <= DATA_W'({hi_q, rx_byte});
      end else if (clr) begin
        addr_q <= '0;
      end
    end
  end

  assign pm_we    = we_q;
  assign pm_addr  = addr_q;
  assign pm_wdata = wdata_q;

endmodule

// File: rtl/prog_mem_loader.sv
// Program-memory loader: parses framed bytes
//   SYNC, LEN_HI, LEN_LO, N x (HI, LO), CHK
// writes the N words sequentially from address 0 and releases the CPU only
// after a frame whose byte sum (everything after SYNC, incl. CHK) is zero.
// Optional macro PML_TIMEOUT_EN: inter-byte timeout of TIMEOUT_CYC cycles
// forces the frame into the error state.
// Ports:
//   clk, rst_n          clock, asynchronous active-low reset
//   rx_valid/rx_data    incoming byte; consumed when rx_valid && rx_ready
//   rx_ready            low only during a program-memory write cycle
//   pm_we/addr/wdata    program-memory write port
//   cpu_hold            1 keeps the CPU in reset
//   load_done/load_err  outcome of the last frame
module prog_mem_loader
  import pml_pkg::*;
#(
  parameter int unsigned ADDR_W      = PML_ADDR_W,
  parameter int unsigned DATA_W      = PML_DATA_W,
  parameter logic [7:0]  SYNC_BYTE   = PML_SYNC_BYTE,
  parameter int unsigned TIMEOUT_CYC = 100000
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              rx_valid,
  input  logic [7:0]        rx_data,
  output logic              rx_ready,
  output logic              pm_we,
  output logic [ADDR_W-1:0] pm_addr,
  output logic [DATA_W-1:0] pm_wdata,
  output logic              cpu_hold,
  output logic              load_done,
  output logic              load_err
);

  pml_state_e        state_q, state_d;
  logic [ADDR_W-1:0] idx_q;
  logic [ADDR_W-1:0] n_q;
  logic [2:0]        len_hi_q;
  logic [7:0]        sum_q;

  logic        accept;
  logic        start;
  logic        in_frame;
  logic        hi_bad;
  logic        hi_load;
  logic        lo_load;
  logic [10:0] len_w;
  logic [7:0]  sum_next;
  logic        tmo_hit;

  assign accept   = rx_valid && rx_ready;
  assign in_frame = pml_in_frame(state_q);
  // SYNC restarts only outside a frame; inside one it is ordinary data.
  assign start    = accept && !in_frame && (rx_data == SYNC_BYTE);
  assign hi_load  = accept && (state_q == StWHi) && !hi_bad;
  assign lo_load  = accept && (state_q == StWLo);
  assign len_w    = {len_hi_q, rx_data};
  assign sum_next = sum_q + rx_data;

`ifdef PML_TIMEOUT_EN
  localparam int unsigned TMO_W = $clog2(TIMEOUT_CYC) + 1;
  logic [TMO_W-1:0] tmo_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tmo_q <= '0;
    end else if (accept || !in_frame) begin
      tmo_q <= '0;
    end else begin
      tmo_q <= tmo_q + TMO_W'(1);
    end
  end

  assign tmo_hit = in_frame && (tmo_q == TMO_W'(TIMEOUT_CYC - 1));
`else
  assign tmo_hit = 1'b0;
`endif

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle, StDone, StErr: if (start) state_d = StLenHi;
      StLenHi: if (accept) state_d = (|rx_data[7:3]) ? StErr : StLenLo;
      StLenLo: if (accept) state_d = (len_w == '0) ? StErr : StWHi;
      StWHi:   if (accept) state_d = hi_bad ? StErr : StWLo;
      StWLo:   if (accept) state_d = (idx_q + ADDR_W'(1) == n_q) ? StChk : StWHi;
      StChk:   if (accept) state_d = (sum_next == 8'h00) ? StDone : StErr;
      default: state_d = StIdle;
    endcase
    if (tmo_hit && !accept) begin
      state_d = StErr;
    end
  end

  // Outputs
  always_comb begin
    rx_ready  = !pm_we;
    cpu_hold  = (state_q != StDone);
    load_done = (state_q == StDone);
    load_err  = (state_q == StErr);
  end

  // Frame datapath: length, word index and running checksum
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      idx_q    <= '0;
      n_q      <= '0;
      len_hi_q <= '0;
      sum_q    <= '0;
    end else if (start) begin
      idx_q <= '0;
      sum_q <= '0;
    end else if (accept && in_frame) begin
      sum_q <= sum_next;
      if (state_q == StLenHi) len_hi_q <= rx_data[2:0];
      if (state_q == StLenLo) n_q <= ADDR_W'(len_w);
      if (lo_load) idx_q <= idx_q + ADDR_W'(1);
    end
  end

  pml_word_asm #(
    .ADDR_W (ADDR_W),
    .DATA_W (DATA_W)
  ) u_word_asm (
    .clk      (clk),
    .rst_n    (rst_n),
    .clr      (start),
    .hi_load  (hi_load),
    .lo_load  (lo_load),
    .rx_byte  (rx_data),
    .wr_idx   (idx_q),
    .hi_bad   (hi_bad),
    .pm_we    (pm_we),
    .pm_addr  (pm_addr),
    .pm_wdata (pm_wdata)
  );

endmodule
